gmii_tx_arbiter: RTL and testbench
==================================

GMII_TX_ARBITER -- requirements
Module: gmii_tx_arbiter

Interface
REQ-001 Parameter IFG_BYTES, default 12, idle cycles enforced between frames (minimum 12).
REQ-002 Parameter MAX_DATA, default 1514, maximum payload bytes accepted per frame, excluding FCS.
REQ-003 Port clock  in  1  GMII transmit clock; the block's single clock.
REQ-004 Port reset  in  1  synchronous, active-high reset.
REQ-005 Ports s0_valid, s1_valid  in  1 each  requester has a byte available.
REQ-006 Ports s0_data, s1_data  in  8 each  requester byte (TypeByte).
REQ-007 Ports s0_last, s1_last  in  1 each  current byte ends the frame.
REQ-008 Ports s0_ready, s1_ready  out  1 each  byte is accepted this cycle when valid and ready are both high.
REQ-009 Port tx_data  out  8  GMII TXD, registered.
REQ-010 Port tx_en  out  1  GMII TX_EN, registered.
REQ-011 Port tx_er  out  1  GMII TX_ER, registered.
REQ-012 Port grant  out  1  index of the requester owning the current frame; valid while busy.
REQ-013 Port busy  out  1  high in every state except IDLE.
REQ-014 Port err_underrun  out  1  one-cycle pulse when a frame is aborted.

Function
REQ-015 FSM states SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS and IFG.
REQ-016 IDLE: if any valid is high, SHALL grant round-robin (priority to the requester not served last; tie after reset goes to s0), latch grant and enter PREAMBLE next cycle.
REQ-017 PREAMBLE: SHALL drive 7 cycles of tx_data=0x55 with tx_en=1; SFD: SHALL drive 1 cycle of 0xD5.
REQ-018 DATA: SHALL raise ready only for the granted requester; an accepted byte SHALL appear on tx_data on the next cycle with tx_en=1 and SHALL be folded into the CRC.
REQ-019 The non-granted ready SHALL be 0 in every state; both readys SHALL be 0 outside DATA.
REQ-020 When a byte with last=1 is accepted, SHALL enter PAD if the payload is under 60 bytes and padding is compiled in (REQ-031), otherwise FCS.
REQ-021 PAD: SHALL drive 0x00 bytes, each included in the CRC, until the payload totals 60 bytes.
REQ-022 FCS: SHALL drive 4 bytes, least-significant byte first, equal to the bitwise complement of the reflected IEEE 802.3 CRC-32 (init 0xFFFFFFFF) over the payload and any pad bytes; then SHALL enter IFG.
REQ-023 IFG: SHALL hold tx_en=0 for IFG_BYTES cycles, then return to IDLE; no grant is issued during IFG.
REQ-024 Underrun: if the granted valid is low in DATA before last, SHALL drive tx_en=1, tx_er=1 for one cycle, pulse err_underrun, skip FCS and enter IFG.
REQ-025 Oversize: accepting byte MAX_DATA+1 without last SHALL be treated as an underrun abort.
REQ-026 The payload counter SHALL be 11 bits and saturate; it SHALL never wrap.
REQ-027 tx_er SHALL be 0 except in the abort cycle; tx_data SHALL be 0x00 whenever tx_en=0.
REQ-028 Latency: a valid in IDLE at cycle N SHALL produce the first preamble byte at cycle N+2; the first payload byte SHALL appear 8 cycles after the first preamble byte.

Reset
REQ-029 Reset SHALL force IDLE, tx_en=0, tx_er=0, tx_data=0x00, readys=0, grant=0, busy=0, err_underrun=0, CRC=0xFFFFFFFF, and set the round-robin pointer to favour s0.
REQ-030 Reset mid-frame SHALL drop tx_en on the next edge, with no FCS and no IFG enforced.

Configuration
REQ-031 With macro GMII_TX_PAD_EN defined: short frames SHALL be zero-padded to 60 payload bytes. Without it: the PAD state SHALL be absent, frames SHALL be sent as supplied, and a 60-byte frame and a 1-byte frame SHALL differ only in length.

Structure
REQ-032 Package eth_pkg SHALL hold TypeByte, PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_INIT=0xFFFFFFFF, MIN_PAYLOAD=60 and the FSM state enum.
REQ-033 One sub-module, tx_crc32_d8, SHALL be a combinational byte-wide CRC-32 step (crc, data -> next crc), instantiated once; the CRC register and FSM live in gmii_tx_arbiter.

Verification
REQ-034 s0 sends 9 bytes "123456789" with padding compiled out -> 7x0x55, 0xD5, the 9 bytes, then FCS 0x26 0x39 0xF4 0xCB, then 12 cycles of tx_en=0.
REQ-035 s0 sends a 1-byte frame with GMII_TX_PAD_EN defined -> exactly 60 payload bytes (59 are 0x00), then a 4-byte FCS matching a reference CRC of the padded payload; total tx_en=1 cycles = 72.
REQ-036 s0 and s1 hold valid continuously -> grants alternate 0,1,0,1; no frames overlap; at least 12 idle cycles between frames.
REQ-037 s1 drops valid after 5 bytes without last -> one cycle with tx_er=1 and tx_en=1, one err_underrun pulse, no FCS, then IFG.
REQ-038 Reset asserted during byte 20 of the payload -> tx_en=0 on the next cycle, all outputs at reset values, next grant goes to s0.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet transmit types and constants.
//   TypeByte       - one GMII data byte
//   PREAMBLE_BYTE  - 0x55, sent seven times before the SFD
//   SFD_BYTE       - 0xD5, start-of-frame delimiter
//   CRC_INIT       - CRC-32 register start value
//   CRC_POLY       - reflected IEEE 802.3 CRC-32 polynomial
//   MIN_PAYLOAD    - minimum payload length when padding is built in
//   state_t        - transmitter FSM states
// Optional feature: GMII_TX_PAD_EN adds the PAD state.
package eth_pkg;

  typedef logic [7:0] TypeByte;

  localparam TypeByte     PREAMBLE_BYTE = 8'h55;
  localparam TypeByte     SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [10:0] MIN_PAYLOAD   = 11'd60;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    DATA     = 3'd3,
`ifdef GMII_TX_PAD_EN
    PAD      = 3'd4,
`endif
    FCS      = 3'd5,
    IFG      = 3'd6
  } state_t;

endpackage

// File: rtl/tx_crc32_d8.sv
// tx_crc32_d8: combinational one-byte step of the reflected CRC-32.
// Ports:
//   crc      in  32  current CRC register value
//   data     in  8   byte to fold in (LSB processed first)
//   crc_next out 32  CRC register value after the byte
module tx_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  TypeByte     data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int b = 0; b < 8; b++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC_POLY) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: two-requester round-robin GMII transmitter.
// Frames a requester's byte stream with preamble, SFD, optional padding and
// FCS, then enforces an inter-frame gap.
// Parameters:
//   IFG_BYTES - idle cycles between frames (values below 12 are raised to 12)
//   MAX_DATA  - largest payload accepted per frame, FCS excluded
// Ports:
//   clock, reset                 GMII TX clock, synchronous active-high reset
//   s0_/s1_ valid, data, last    requester byte streams
//   s0_/s1_ ready                byte accepted when valid && ready
//   tx_data, tx_en, tx_er        registered GMII transmit outputs
//   grant                        requester owning the current frame
//   busy                         FSM is not IDLE
//   err_underrun                 one-cycle pulse on a frame abort
// Optional feature: define GMII_TX_PAD_EN to zero-pad short frames to
// MIN_PAYLOAD bytes; otherwise frames are sent exactly as supplied.
module gmii_tx_arbiter
  import eth_pkg::*;
#(
  parameter int IFG_BYTES = 12,
  parameter int MAX_DATA  = 1514
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    s0_valid,
  input  TypeByte s0_data,
  input  logic    s0_last,
  output logic    s0_ready,
  input  logic    s1_valid,
  input  TypeByte s1_data,
  input  logic    s1_last,
  output logic    s1_ready,
  output TypeByte tx_data,
  output logic    tx_en,
  output logic    tx_er,
  output logic    grant,
  output logic    busy,
  output logic    err_underrun
);

  localparam int          IFG_EFF  = (IFG_BYTES < 12) ? 12 : IFG_BYTES;
  localparam logic [15:0] IFG_LAST = 16'(IFG_EFF - 1);
  localparam int          MAX_CLIP = (MAX_DATA > 2047) ? 2047 : MAX_DATA;
  localparam logic [10:0] LEN_MAX  = 11'(MAX_CLIP);

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [10:0] len_reg;
  logic [31:0] crc_reg;
  logic        grant_reg;
  logic        prio_reg;       // requester favoured on a tie
  TypeByte     tx_data_reg;
  logic        tx_en_reg;
  logic        tx_er_reg;
  logic        err_underrun_reg;

  logic        sel_valid;
  TypeByte     sel_data;
  logic        sel_last;
  logic        pick;
  logic [10:0] len_next;
  TypeByte     crc_data;
  logic [31:0] crc_next;

  assign sel_valid = grant_reg ? s1_valid : s0_valid;
  assign sel_data  = grant_reg ? s1_data  : s0_data;
  assign sel_last  = grant_reg ? s1_last  : s0_last;

  // Lone requester wins outright; on a tie the favoured one wins.
  assign pick = (s0_valid && s1_valid) ? prio_reg : s1_valid;

  // Payload counter saturates instead of wrapping.
  assign len_next = (len_reg == 11'h7FF) ? len_reg : len_reg + 11'd1;

`ifdef GMII_TX_PAD_EN
  assign crc_data = (state_reg == PAD) ? 8'h00 : sel_data;
`else
  assign crc_data = sel_data;
`endif

  tx_crc32_d8 u_crc (
    .crc      (crc_reg),
    .data     (crc_data),
    .crc_next (crc_next)
  );

  assign s0_ready     = (state_reg == DATA) && !grant_reg;
  assign s1_ready     = (state_reg == DATA) &&  grant_reg;
  assign busy         = (state_reg != IDLE);
  assign grant        = grant_reg;
  assign tx_data      = tx_data_reg;
  assign tx_en        = tx_en_reg;
  assign tx_er        = tx_er_reg;
  assign err_underrun = err_underrun_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      len_reg          <= '0;
      crc_reg          <= CRC_INIT;
      grant_reg        <= 1'b0;
      prio_reg         <= 1'b0;
      tx_data_reg      <= 8'h00;
      tx_en_reg        <= 1'b0;
      tx_er_reg        <= 1'b0;
      err_underrun_reg <= 1'b0;
    end else begin
      // Outputs default to an idle line; states override below.
      tx_data_reg      <= 8'h00;
      tx_en_reg        <= 1'b0;
      tx_er_reg        <= 1'b0;
      err_underrun_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            grant_reg <= pick;
            prio_reg  <= ~pick;
            cnt_reg   <= '0;
            len_reg   <= '0;
            crc_reg   <= CRC_INIT;
            state_reg <= PREAMBLE;
          end
        end
        PREAMBLE: begin
          tx_en_reg   <= 1'b1;
          tx_data_reg <= PREAMBLE_BYTE;
          cnt_reg     <= cnt_reg + 16'd1;
          if (cnt_reg == 16'd6) state_reg <= SFD;
        end
        SFD: begin
          tx_en_reg   <= 1'b1;
          tx_data_reg <= SFD_BYTE;
          state_reg   <= DATA;
        end
        DATA: begin
          // A missing byte, or any byte past MAX_DATA, aborts the frame:
          // one tx_er cycle replaces the rest, and no FCS is sent.
          if (!sel_valid || (len_reg >= LEN_MAX)) begin
            tx_en_reg        <= 1'b1;
            tx_er_reg        <= 1'b1;
            err_underrun_reg <= 1'b1;
            cnt_reg          <= '0;
            state_reg        <= IFG;
          end else begin
            tx_en_reg   <= 1'b1;
            tx_data_reg <= sel_data;
            crc_reg     <= crc_next;
            len_reg     <= len_next;
            if (sel_last) begin
              cnt_reg <= '0;
`ifdef GMII_TX_PAD_EN
              state_reg <= (len_next < MIN_PAYLOAD) ? PAD : FCS;
`else
              state_reg <= FCS;
`endif
            end
          end
        end
`ifdef GMII_TX_PAD_EN
        PAD: begin
          tx_en_reg   <= 1'b1;
          tx_data_reg <= 8'h00;
          crc_reg     <= crc_next;
          len_reg     <= len_next;
          if (len_next == MIN_PAYLOAD) begin
            cnt_reg   <= '0;
            state_reg <= FCS;
          end
        end
`endif
        FCS: begin
          // FCS is the complemented register, least-significant byte first.
          tx_en_reg   <= 1'b1;
          tx_data_reg <= ~crc_reg[{cnt_reg[1:0], 3'b000} +: 8];
          cnt_reg     <= cnt_reg + 16'd1;
          if (cnt_reg == 16'd3) begin
            cnt_reg   <= '0;
            state_reg <= IFG;
          end
        end
        IFG: begin
          cnt_reg <= cnt_reg + 16'd1;
          if (cnt_reg == IFG_LAST) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// tb_gmii_tx_arbiter: scoreboard bench for gmii_tx_arbiter.
// Stimulus tasks push expected GMII frames into queues; a monitor on the
// falling edge pops and compares every transmitted byte, frame length,
// grant and inter-frame gap. Builds with or without GMII_TX_PAD_EN.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       s0_ready, s1_ready;
  logic [7:0] tx_data;
  logic       tx_en, tx_er, grant, busy, err_underrun;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];       // {abort flag, byte}
  int         exp_len_q[$];
  int         exp_grant_q[$];

  bit mon_en   = 1'b1;
  bit in_frame = 1'b0;
  int flen     = 0;
  int gap      = 100;
  int pulses   = 0;

  gmii_tx_arbiter #(.IFG_BYTES(12), .MAX_DATA(1514)) dut (
    .clock        (clock),
    .reset        (reset),
    .s0_valid     (s0_valid),
    .s0_data      (s0_data),
    .s0_last      (s0_last),
    .s0_ready     (s0_ready),
    .s1_valid     (s1_valid),
    .s1_data      (s1_data),
    .s1_last      (s1_last),
    .s1_ready     (s1_ready),
    .tx_data      (tx_data),
    .tx_en        (tx_en),
    .tx_er        (tx_er),
    .grant        (grant),
    .busy         (busy),
    .err_underrun (err_underrun)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s actual=%s required=%s", name, act, req);
  endtask

  function automatic logic [31:0] fcs_ref(input logic [7:0] p[$]);
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (p[k]) begin
      c = c ^ {24'h0, p[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic push_hdr();
    for (int k = 0; k < 7; k++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
  endtask

  task automatic push_frame(input int g, input logic [7:0] p[$]);
    logic [7:0]  full[$];
    logic [31:0] f;
    full = p;
`ifdef GMII_TX_PAD_EN
    while (full.size() < 60) full.push_back(8'h00);
`endif
    f = fcs_ref(full);
    push_hdr();
    foreach (full[k]) exp_q.push_back({1'b0, full[k]});
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, f[8*k +: 8]});
    exp_len_q.push_back(8 + full.size() + 4);
    exp_grant_q.push_back(g);
  endtask

  task automatic push_abort(input int g, input logic [7:0] p[$]);
    push_hdr();
    foreach (p[k]) exp_q.push_back({1'b0, p[k]});
    exp_q.push_back({1'b1, 8'h00});
    exp_len_q.push_back(8 + p.size() + 1);
    exp_grant_q.push_back(g);
  endtask

  task automatic set_src(input int src, input logic v, input logic [7:0] d, input logic l);
    if (src == 0) begin s0_valid = v; s0_data = d; s0_last = l; end
    else          begin s1_valid = v; s1_data = d; s1_last = l; end
  endtask

  // Present bytes one per falling edge; advance when ready is seen.
  task automatic drive(input int src, input logic [7:0] p[$], input bit nolast);
    int i = 0;
    int cyc = 0;
    while (i < p.size()) begin
      @(negedge clock);
      set_src(src, 1'b1, p[i], (i == p.size() - 1) && !nolast);
      if ((src == 0) ? s0_ready : s1_ready) i++;
      cyc++;
      if (cyc > 400) begin
        fail("drive_timeout", "no_ready", "ready");
        break;
      end
    end
  endtask

  task automatic clr(input int src);
    @(negedge clock);
    set_src(src, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || in_frame || gap < 14) && cyc < 600) begin
      @(negedge clock);
      cyc++;
    end
    if (cyc >= 600) fail({name, "_drain"}, "timeout", "idle");
    chk({name, "_frames_left"}, exp_len_q.size(), 0);
  endtask

  // Monitor / scoreboard.
  always @(negedge clock) begin
    logic [8:0] e;
    if (reset || !mon_en) begin
      in_frame = 1'b0;
      gap = 100;
    end else begin
      chk("nongrant_ready", grant ? s0_ready : s1_ready, 0);
      if (!busy) chk("idle_ready", {s0_ready, s1_ready}, 0);
      if (err_underrun) pulses++;
      if (tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          flen = 0;
          chk("ifg_gap_ge_12", gap >= 12, 1);
          if (exp_grant_q.size() == 0) fail("unexpected_frame", "frame", "none");
          else chk("grant", grant, exp_grant_q.pop_front());
        end
        flen++;
        if (exp_q.size() == 0) begin
          fail("extra_byte", "byte", "none");
        end else begin
          e = exp_q.pop_front();
          if (e[8]) chk("abort_cycle", {tx_er, err_underrun, busy}, 3'b111);
          else chk("byte", {tx_er, err_underrun, busy, tx_data}, {3'b001, e[7:0]});
        end
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          gap = 0;
          if (exp_len_q.size() == 0) fail("frame_len", "frame", "none");
          else chk("frame_len", flen, exp_len_q.pop_front());
        end
        gap++;
        chk("idle_line", {tx_er, err_underrun, tx_data}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] p9[$], p1[$], p5[$], pa[$], pb[$], pc[$], pd[$], p30[$], q0[$], q1[$];
    logic [7:0] lit[$];
    int i, cyc;
    bit hit;

    p9 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    p1 = {8'hA5};
    p5 = {8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    pa = {8'hA0, 8'hA1, 8'hA2};
    pb = {8'hB0, 8'hB1, 8'hB2, 8'hB3};
    pc = {8'hC0, 8'hC1};
    pd = {8'hD0, 8'hD1, 8'hD2};
    q0 = {8'hE0, 8'hE1};
    q1 = {8'hF0, 8'hF1};
    for (int k = 0; k < 30; k++) p30.push_back(8'(8'h40 + k));

    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset_outputs", {tx_en, tx_er, tx_data, s0_ready, s1_ready, grant, busy, err_underrun}, 0);
    reset = 1'b0;

    // "123456789" from s0.
`ifdef GMII_TX_PAD_EN
    push_frame(0, p9);
`else
    lit = {8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
           8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
           8'h26, 8'h39, 8'hF4, 8'hCB};
    foreach (lit[k]) exp_q.push_back({1'b0, lit[k]});
    exp_len_q.push_back(21);
    exp_grant_q.push_back(0);
`endif
    drive(0, p9, 1'b0);
    clr(0);
    drain("crc_check");

    // One-byte frame (padded to 60 when padding is built in).
    push_frame(0, p1);
    drive(0, p1, 1'b0);
    clr(0);
    drain("short_frame");

    // s1 underrun after 5 bytes.
    pulses = 0;
    push_abort(1, p5);
    drive(1, p5, 1'b1);
    clr(1);
    drain("underrun");
    chk("underrun_pulses", pulses, 1);

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    push_frame(0, pa);
    push_frame(1, pb);
    push_frame(0, pc);
    push_frame(1, pd);
    fork
      begin drive(0, pa, 1'b0); drive(0, pc, 1'b0); clr(0); end
      begin drive(1, pb, 1'b0); drive(1, pd, 1'b0); clr(1); end
    join
    drain("round_robin");
    chk("no_extra_pulses", pulses, 1);

    // Reset while byte 20 of an s0 frame is being accepted.
    mon_en = 1'b0;
    i = 0;
    cyc = 0;
    hit = 1'b0;
    while (!hit && cyc < 300) begin
      @(negedge clock);
      cyc++;
      s0_valid = 1'b1;
      s0_data  = p30[i];
      s0_last  = 1'b0;
      if (s0_ready) begin
        if (i == 19) begin
          hit = 1'b1;
          chk("byte19_on_wire", {tx_en, tx_data}, {1'b1, p30[18]});
          reset = 1'b1;
        end else begin
          i++;
        end
      end
    end
    if (!hit) fail("reset_test_timeout", "no_byte20", "byte20");
    @(negedge clock);
    chk("midframe_reset_outputs",
        {tx_en, tx_er, tx_data, s0_ready, s1_ready, grant, busy, err_underrun}, 0);
    s0_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    // After reset the tie goes to s0 even though s0 was served last.
    push_frame(0, q0);
    push_frame(1, q1);
    fork
      begin drive(0, q0, 1'b0); clr(0); end
      begin drive(1, q1, 1'b0); clr(1); end
    join
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
